gfx_dram_write_arbiter: RTL and testbench

- Shares one DRAM write-request path (address FIFO `af_*` plus write-data FIFO `wdf_*`) between two write masters: requester 0 = line engine, requester 1 = frame filler / clear engine.
- Grants whole burst transactions, one at a time, round-robin.
- A grant never splits a transaction: one address-FIFO entry plus BEATS write-data beats.
- Sits between the graphics engines and the memory-controller FIFOs.

---
 rtl/gfx_dram_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_gfx_dram_write_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_dram_write_arbiter.sv
// Round-robin arbiter sharing one DRAM write path (address + write-data FIFOs) between two
// masters; each grant covers exactly one address entry plus BEATS data beats.
module gfx_dram_write_arbiter #(
    parameter int unsigned BEATS  = 2,
    parameter int unsigned ADDR_W = 31,
    parameter int unsigned DATA_W = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0,
    input  logic                req1,
    output logic                gnt0,
    output logic                gnt1,
    input  logic                af_wr_en0,
    input  logic                af_wr_en1,
    input  logic [ADDR_W-1:0]   af_addr0,
    input  logic [ADDR_W-1:0]   af_addr1,
    output logic                af_full0,
    output logic                af_full1,
    input  logic                wdf_wr_en0,
    input  logic                wdf_wr_en1,
    input  logic [DATA_W-1:0]   wdf_din0,
    input  logic [DATA_W-1:0]   wdf_din1,
    input  logic [DATA_W/8-1:0] wdf_mask0,
    input  logic [DATA_W/8-1:0] wdf_mask1,
    output logic                wdf_full0,
    output logic                wdf_full1,
    input  logic                af_full,
    input  logic                wdf_full,
    output logic [2:0]          af_cmd_din,
    output logic [ADDR_W-1:0]   af_addr_din,
    output logic                af_wr_en,
    output logic [DATA_W-1:0]   wdf_din,
    output logic [DATA_W/8-1:0] wdf_mask_din,
    output logic                wdf_wr_en
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = $clog2(BEATS + 1);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               af_done_q;
    logic               rr_q;

    logic               owned;
    logic               own_req, other_req;
    logic               own_af_wr_en, own_wdf_wr_en;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_din;
    logic [MASK_W-1:0]  own_mask;
    logic               beats_done;
    logic               af_acc, wdf_acc;
    logic               af_done_nx;
    logic [CNT_W-1:0]   beat_cnt_nx;
    logic               complete, abort;
    state_e             other_state;

    assign gnt0  = (state_q == StOwn0);
    assign gnt1  = (state_q == StOwn1);
    assign owned = gnt0 | gnt1;

    always_comb begin
        own_req       = 1'b0;
        other_req     = 1'b0;
        own_af_wr_en  = 1'b0;
        own_wdf_wr_en = 1'b0;
        own_addr      = '0;
        own_din       = '0;
        own_mask      = '1;
        other_state   = StIdle;
        case (state_q)
            StOwn0: begin
                own_req       = req0;
                other_req     = req1;
                own_af_wr_en  = af_wr_en0;
                own_wdf_wr_en = wdf_wr_en0;
                own_addr      = af_addr0;
                own_din       = wdf_din0;
                own_mask      = wdf_mask0;
                other_state   = StOwn1;
            end
            StOwn1: begin
                own_req       = req1;
                other_req     = req0;
                own_af_wr_en  = af_wr_en1;
                own_wdf_wr_en = wdf_wr_en1;
                own_addr      = af_addr1;
                own_din       = wdf_din1;
                own_mask      = wdf_mask1;
                other_state   = StOwn0;
            end
            default: ;
        endcase
    end

    // The counter never exceeds BEATS, so equality is the "< BEATS" gate.
    assign beats_done   = (beat_cnt_q == CNT_W'(BEATS));
    assign af_cmd_din   = 3'b000;
    assign af_addr_din  = own_addr;
    assign wdf_din      = own_din;
    assign wdf_mask_din = own_mask;
    assign af_wr_en     = own_af_wr_en & ~af_done_q;
    assign wdf_wr_en    = own_wdf_wr_en & ~beats_done;

    assign af_full0  = gnt0 ? (af_full | af_done_q) : 1'b1;
    assign af_full1  = gnt1 ? (af_full | af_done_q) : 1'b1;
    assign wdf_full0 = gnt0 ? (wdf_full | beats_done) : 1'b1;
    assign wdf_full1 = gnt1 ? (wdf_full | beats_done) : 1'b1;

    assign af_acc      = af_wr_en & ~af_full;
    assign wdf_acc     = wdf_wr_en & ~wdf_full;
    assign af_done_nx  = af_done_q | af_acc;
    assign beat_cnt_nx = beat_cnt_q + CNT_W'(wdf_acc);
    assign complete    = owned & af_done_nx & (beat_cnt_nx == CNT_W'(BEATS));
    // Abort only while nothing of the burst has reached the shared FIFOs.
    assign abort = owned & ~own_req & ~af_done_q & (beat_cnt_q == '0) & ~af_acc & ~wdf_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            beat_cnt_q <= '0;
            af_done_q  <= 1'b0;
            rr_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 && (!req1 || !rr_q)) state_q <= StOwn0;
                    else if (req1)                state_q <= StOwn1;
                end
                StOwn0, StOwn1: begin
                    if (complete) begin
                        beat_cnt_q <= '0;
                        af_done_q  <= 1'b0;
                        rr_q       <= (state_q == StOwn0);
                        if (other_req)     state_q <= other_state;
                        else if (!own_req) state_q <= StIdle;
                    end else if (abort) begin
                        state_q <= StIdle;
                    end else begin
                        af_done_q  <= af_done_nx;
                        beat_cnt_q <= beat_cnt_nx;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_dram_write_arbiter.sv
// Directed bench for gfx_dram_write_arbiter: single grant, contention, backpressure,
// over-issue, abort/lock and mid-transaction reset.
module tb_gfx_dram_write_arbiter;

    localparam int unsigned ADDR_W = 31;
    localparam int unsigned DATA_W = 128;

    logic clk, rst;
    logic req0, req1, gnt0, gnt1;
    logic af_wr_en0, af_wr_en1, af_full0, af_full1;
    logic [ADDR_W-1:0] af_addr0, af_addr1;
    logic wdf_wr_en0, wdf_wr_en1, wdf_full0, wdf_full1;
    logic [DATA_W-1:0] wdf_din0, wdf_din1;
    logic [15:0] wdf_mask0, wdf_mask1;
    logic af_full, wdf_full;
    logic [2:0] af_cmd_din;
    logic [ADDR_W-1:0] af_addr_din;
    logic af_wr_en, wdf_wr_en;
    logic [DATA_W-1:0] wdf_din;
    logic [15:0] wdf_mask_din;

    int n_cmp = 0;
    int n_err = 0;
    int af_pushes = 0;
    int wdf_pushes = 0;
    int af_base, wdf_base;
    logic own1;

    gfx_dram_write_arbiter #(.BEATS(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .af_wr_en0(af_wr_en0), .af_wr_en1(af_wr_en1),
        .af_addr0(af_addr0), .af_addr1(af_addr1),
        .af_full0(af_full0), .af_full1(af_full1),
        .wdf_wr_en0(wdf_wr_en0), .wdf_wr_en1(wdf_wr_en1),
        .wdf_din0(wdf_din0), .wdf_din1(wdf_din1),
        .wdf_mask0(wdf_mask0), .wdf_mask1(wdf_mask1),
        .wdf_full0(wdf_full0), .wdf_full1(wdf_full1),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count what actually lands in the shared FIFOs.
    always @(posedge clk) begin
        if (af_wr_en && !af_full) af_pushes++;
        if (wdf_wr_en && !wdf_full) wdf_pushes++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_off();
        af_wr_en0 = 0; af_wr_en1 = 0; wdf_wr_en0 = 0; wdf_wr_en1 = 0;
    endtask

    initial begin
        rst = 1; req0 = 0; req1 = 0; strobes_off();
        af_addr0 = 31'h0020_0040; af_addr1 = 31'h0110_0200;
        wdf_din0 = 128'hA0; wdf_din1 = 128'hB0;
        wdf_mask0 = 16'h000F; wdf_mask1 = 16'hF000;
        af_full = 0; wdf_full = 0;
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_af_wr_en", af_wr_en, 0);
        chk("rst_wdf_wr_en", wdf_wr_en, 0);
        chk("rst_addr", af_addr_din, 0);
        chk("rst_din", wdf_din, 0);
        chk("rst_mask", wdf_mask_din, 16'hFFFF);
        chk("rst_cmd", af_cmd_din, 0);
        chk("rst_af_full0", af_full0, 1);
        chk("rst_wdf_full1", wdf_full1, 1);
        step(); step();
        rst = 0;

        // Single requester
        step();
        req0 = 1; #1;
        chk("single_gnt0_pre", gnt0, 0);
        step();
        chk("single_gnt0", gnt0, 1);
        af_wr_en0 = 1; wdf_wr_en0 = 1; wdf_din0 = 128'hA1; #1;
        chk("single_af_wr_en", af_wr_en, 1);
        chk("single_addr", af_addr_din, 31'h0020_0040);
        chk("single_wdf_wr_en", wdf_wr_en, 1);
        chk("single_din1", wdf_din, 128'hA1);
        chk("single_mask", wdf_mask_din, 16'h000F);
        chk("single_af_full0", af_full0, 0);
        chk("single_wdf_full0", wdf_full0, 0);
        chk("single_af_full1", af_full1, 1);
        step();
        af_wr_en0 = 0; wdf_din0 = 128'hA2; req0 = 0; #1;
        chk("single_af_done_full0", af_full0, 1);
        chk("single_din2", wdf_din, 128'hA2);
        chk("single_gnt0_locked", gnt0, 1);
        step();
        strobes_off(); #1;
        chk("single_idle", gnt0, 0);
        chk("single_af_pushes", af_pushes, 1);
        chk("single_wdf_pushes", wdf_pushes, 2);

        // Contention: rr now points at requester 1
        af_base = af_pushes; wdf_base = wdf_pushes;
        req0 = 1; req1 = 1;
        af_wr_en0 = 1; af_wr_en1 = 1; wdf_wr_en0 = 1; wdf_wr_en1 = 1;
        step();
        for (int k = 0; k < 12; k++) begin
            if (k == 11) begin req0 = 0; req1 = 0; end
            #1;
            own1 = ((k / 2) % 2 == 0);
            chk("cont_gnt1", gnt1, own1);
            chk("cont_gnt0", gnt0, !own1);
            chk("cont_af_wr_en", af_wr_en, (k % 2 == 0));
            chk("cont_addr", af_addr_din, own1 ? af_addr1 : af_addr0);
            chk("cont_din", wdf_din, own1 ? wdf_din1 : wdf_din0);
            chk("cont_nonown_af_full", own1 ? af_full0 : af_full1, 1);
            chk("cont_nonown_wdf_full", own1 ? wdf_full0 : wdf_full1, 1);
            chk("cont_own_af_full", own1 ? af_full1 : af_full0, (k % 2 == 1));
            step();
        end
        strobes_off(); #1;
        chk("cont_idle0", gnt0, 0);
        chk("cont_idle1", gnt1, 0);
        chk("cont_af_pushes", af_pushes - af_base, 6);
        chk("cont_wdf_pushes", wdf_pushes - wdf_base, 12);

        // Backpressure with owner 1
        af_base = af_pushes; wdf_base = wdf_pushes;
        req1 = 1;
        step();
        chk("bp_gnt1", gnt1, 1);
        af_wr_en1 = 1; wdf_wr_en1 = 1; wdf_din1 = 128'hB1;
        step();
        af_wr_en1 = 0; wdf_din1 = 128'hB2; wdf_full = 1; req0 = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_gnt1_held", gnt1, 1);
            chk("bp_gnt0_low", gnt0, 0);
            chk("bp_wdf_full1", wdf_full1, 1);
            chk("bp_wdf_stalled", wdf_pushes - wdf_base, 1);
            step();
        end
        wdf_full = 0; req1 = 0; #1;
        chk("bp_wdf_full1_clear", wdf_full1, 0);
        step();
        strobes_off(); #1;
        chk("bp_wdf_pushes", wdf_pushes - wdf_base, 2);
        chk("bp_af_pushes", af_pushes - af_base, 1);
        chk("bp_handoff_gnt0", gnt0, 1);
        chk("bp_handoff_gnt1", gnt1, 0);

        // Abort: req0 drops in the grant cycle with nothing written
        req0 = 0;
        step();
        chk("abort_idle", gnt0, 0);

        // Over-issue: 3 data strobes, then address, then a stray address strobe
        af_base = af_pushes; wdf_base = wdf_pushes;
        req0 = 1;
        step();
        chk("over_gnt0", gnt0, 1);
        wdf_wr_en0 = 1; wdf_din0 = 128'hC1;
        step();
        wdf_din0 = 128'hC2; #1;
        chk("over_beat2_en", wdf_wr_en, 1);
        step();
        wdf_din0 = 128'hC3; af_wr_en0 = 1; req0 = 0; #1;
        chk("over_wdf_full0", wdf_full0, 1);
        chk("over_beat3_blocked", wdf_wr_en, 0);
        chk("over_af_en", af_wr_en, 1);
        step();
        #1;
        chk("over_idle", gnt0, 0);
        chk("over_af_full0", af_full0, 1);
        chk("over_af2_blocked", af_wr_en, 0);
        step();
        strobes_off();
        chk("over_af_pushes", af_pushes - af_base, 1);
        chk("over_wdf_pushes", wdf_pushes - wdf_base, 2);

        // Lock: req0 drops after one accepted beat
        af_base = af_pushes; wdf_base = wdf_pushes;
        req0 = 1;
        step();
        chk("lock_gnt0", gnt0, 1);
        wdf_wr_en0 = 1;
        step();
        req0 = 0; strobes_off(); #1;
        chk("lock_held_a", gnt0, 1);
        step();
        chk("lock_held_b", gnt0, 1);
        chk("lock_af_full0", af_full0, 0);
        chk("lock_wdf_full0", wdf_full0, 0);
        af_wr_en0 = 1; wdf_wr_en0 = 1;
        step();
        strobes_off(); #1;
        chk("lock_idle", gnt0, 0);
        chk("lock_af_pushes", af_pushes - af_base, 1);
        chk("lock_wdf_pushes", wdf_pushes - wdf_base, 2);

        // Reset mid-transaction
        req0 = 1;
        step();
        chk("rstmid_gnt0", gnt0, 1);
        wdf_wr_en0 = 1;
        step();
        wdf_base = wdf_pushes;
        rst = 1; req0 = 0; req1 = 1; #1;
        chk("rstmid_gnt0_low", gnt0, 0);
        chk("rstmid_gnt1_low", gnt1, 0);
        chk("rstmid_mask", wdf_mask_din, 16'hFFFF);
        chk("rstmid_wdf_wr_en", wdf_wr_en, 0);
        chk("rstmid_af_wr_en", af_wr_en, 0);
        step();
        chk("rstmid_no_push", wdf_pushes - wdf_base, 0);
        rst = 0; strobes_off(); #1;
        chk("rstmid_gnt1_pre", gnt1, 0);
        step();
        chk("rstmid_gnt1", gnt1, 1);
        chk("rstmid_af_full1", af_full1, 0);
        req1 = 0;
        step();
        chk("rstmid_abort", gnt1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
